spi_slave_ctrl: RTL and testbench

Frame controller for the SPI slave front end. It watches `SS_n`/`MOSI`, decodes the command bit, deserializes 10-bit words for the single-port RAM, and tracks read-address/read-data sequencing. For read-data frames it waits for the RAM's `tx_valid`, then times the 8-cycle MISO serialization performed by the parallel-to-serial converter. It sits between the SPI pins, the RAM and the converter.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_rx_shifter.sv | 47 ++++
 rtl/spi_slave_ctrl.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared definitions for the SPI slave frame controller: word
//            width, command codes and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Received word is {cmd[1:0], payload[7:0]}
  localparam int WORD_W = 10;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4,
    ST_TX_WAIT   = 3'd5,
    ST_TX_SHIFT  = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_rx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_rx_shifter
// Purpose  : MSB-first MOSI deserializer with bit counter. Presents the word
//            that will be complete once the current input bit is captured,
//            and flags when the bit being presented is the last one.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rx_shifter
  import spi_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] word,
  output logic             last_bit
);

  localparam int CNT_W = 4;

  // Only WIDTH-1 bits need storage: the final bit is taken straight from din
  logic [WIDTH-2:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;

  // Shift register and bit counter; clear has priority over shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (clr) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (shift_en) begin
      r_shreg <= {r_shreg[WIDTH-3:0], din};
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign word     = {r_shreg, din};
  assign last_bit = (r_cnt == CNT_W'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_ctrl
// Purpose  : SPI slave frame controller. Decodes the command bit, collects
//            10-bit words for the RAM, tracks read-address/read-data pairing
//            and times the MISO serialization window after RAM tx_valid.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_active,
  output logic              rd_addr_pending,
  output logic              tx_err
);

  localparam int WAIT_W  = $clog2(TX_TIMEOUT + 1);
  localparam int SHIFT_W = $clog2(DATA_W + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TX_TIMEOUT - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(DATA_W - 1);

  state_t r_state;
  state_t w_next_state;

  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [SHIFT_W-1:0] r_shift_cnt;

  logic              w_shift_en;
  logic              w_load_rx;
  logic              w_set_pend;
  logic              w_clr_pend;
  logic              w_timeout;
  logic              w_rx_clr;
  logic              w_last_bit;
  logic [WORD_W-1:0] w_rx_word;

  // Counter restarts whenever a new frame begins
  assign w_rx_clr = (r_state == ST_IDLE);

  spi_rx_shifter #(
    .WIDTH (WORD_W)
  ) u_rx_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_rx_clr),
    .shift_en (w_shift_en),
    .din      (MOSI),
    .word     (w_rx_word),
    .last_bit (w_last_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode and one-cycle control strobes
  always_comb begin
    w_next_state = r_state;
    w_shift_en   = 1'b0;
    w_load_rx    = 1'b0;
    w_set_pend   = 1'b0;
    w_clr_pend   = 1'b0;
    w_timeout    = 1'b0;
    if (r_state != ST_IDLE && SS_n) begin
      // Deselect aborts anything in flight; partial words are dropped
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!SS_n) w_next_state = ST_CHK_CMD;
        end
        ST_CHK_CMD: begin
          w_shift_en = 1'b1;
          if (!MOSI)                w_next_state = ST_WRITE;
          else if (rd_addr_pending) w_next_state = ST_READ_DATA;
          else                      w_next_state = ST_READ_ADD;
        end
        ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
          w_shift_en = 1'b1;
          if (w_last_bit) begin
            w_load_rx = 1'b1;
            if (r_state == ST_READ_DATA) begin
              w_next_state = ST_TX_WAIT;
            end else begin
              w_next_state = ST_DONE;
              w_set_pend   = (r_state == ST_READ_ADD);
            end
          end
        end
        ST_TX_WAIT: begin
          // tx_valid takes precedence over a simultaneous timeout
          if (tx_valid) begin
            w_next_state = ST_TX_SHIFT;
          end else if (r_wait_cnt == WAIT_LAST) begin
            w_timeout    = 1'b1;
            w_next_state = ST_DONE;
          end
        end
        ST_TX_SHIFT: begin
          if (r_shift_cnt == SHIFT_LAST) begin
            w_clr_pend   = 1'b1;
            w_next_state = ST_DONE;
          end
        end
        ST_DONE: begin
          w_next_state = ST_DONE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Wait and shift counters run only while their state persists
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_shift_cnt <= '0;
    end else begin
      if (r_state == ST_TX_WAIT && w_next_state == ST_TX_WAIT)
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      else
        r_wait_cnt <= '0;
      if (r_state == ST_TX_SHIFT && w_next_state == ST_TX_SHIFT)
        r_shift_cnt <= r_shift_cnt + SHIFT_W'(1);
      else
        r_shift_cnt <= '0;
    end
  end

  // Registered outputs; tx_active mirrors the upcoming TX_SHIFT occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      tx_active       <= 1'b0;
      rd_addr_pending <= 1'b0;
      tx_err          <= 1'b0;
    end else begin
      rx_valid  <= w_load_rx;
      tx_err    <= w_timeout;
      tx_active <= (w_next_state == ST_TX_SHIFT);
      if (w_load_rx) rx_data <= w_rx_word;
      if (w_set_pend)      rd_addr_pending <= 1'b1;
      else if (w_clr_pend) rd_addr_pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_ctrl
// Purpose  : Directed self-checking bench for spi_slave_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       tx_valid = 1'b0;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       tx_active;
  logic       rd_addr_pending;
  logic       tx_err;

  int checks = 0;
  int errors = 0;

  spi_slave_ctrl #(
    .DATA_W     (8),
    .TX_TIMEOUT (15)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .SS_n            (SS_n),
    .MOSI            (MOSI),
    .tx_valid        (tx_valid),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .tx_active       (tx_active),
    .rd_addr_pending (rd_addr_pending),
    .tx_err          (tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, return 1ns after the sampling rising edge
  task automatic step(input logic ss, input logic mosi, input logic txv);
    @(negedge clk);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = txv;
    @(posedge clk);
    #1;
  endtask

  // E0 (select) followed by bits 9..0; returns in the cycle after E10
  task automatic send_word(input logic [9:0] w);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) step(1'b0, w[i], 1'b0);
  endtask

  function automatic logic [31:0] st(input state_t s);
    return 32'(s);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] w;

    // ---------------- reset ----------------
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_data",   32'(rx_data), 32'h0);
    chk("rst_rx_valid",  32'(rx_valid), 32'h0);
    chk("rst_tx_active", 32'(tx_active), 32'h0);
    chk("rst_pending",   32'(rd_addr_pending), 32'h0);
    chk("rst_tx_err",    32'(tx_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk("idle_state", 32'(dut.r_state), st(ST_IDLE));

    // ---------------- write-address frame ----------------
    w = 10'b0010100101;
    send_word(w);
    chk("wr_rx_valid", 32'(rx_valid), 32'h1);
    chk("wr_rx_data",  32'(rx_data), 32'h0A5);
    chk("wr_state",    32'(dut.r_state), st(ST_DONE));
    chk("wr_pending",  32'(rd_addr_pending), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("wr_rx_valid_drop", 32'(rx_valid), 32'h0);
    chk("wr_done_hold",     32'(dut.r_state), st(ST_DONE));
    step(1'b1, 1'b0, 1'b0);
    chk("wr_idle",      32'(dut.r_state), st(ST_IDLE));
    chk("wr_data_hold", 32'(rx_data), 32'h0A5);

    // ---------------- read pair ----------------
    w = 10'b1000001111;
    send_word(w);
    chk("ra_rx_data", 32'(rx_data), 32'h20F);
    chk("ra_valid",   32'(rx_valid), 32'h1);
    chk("ra_pending", 32'(rd_addr_pending), 32'h1);
    chk("ra_state",   32'(dut.r_state), st(ST_DONE));
    step(1'b1, 1'b0, 1'b0);

    w = 10'b1100000000;
    send_word(w);
    chk("rd_rx_data", 32'(rx_data), 32'h300);
    chk("rd_valid",   32'(rx_valid), 32'h1);
    chk("rd_state",   32'(dut.r_state), st(ST_TX_WAIT));
    step(1'b0, 1'b0, 1'b0);
    chk("rd_no_active_wait", 32'(tx_active), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    chk("rd_active_c1", 32'(tx_active), 32'h1);
    for (int k = 2; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("rd_active_c%0d", k), 32'(tx_active), 32'h1);
      chk($sformatf("rd_pend_c%0d", k), 32'(rd_addr_pending), 32'h1);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("rd_active_end", 32'(tx_active), 32'h0);
    chk("rd_pend_clear", 32'(rd_addr_pending), 32'h0);
    chk("rd_done",       32'(dut.r_state), st(ST_DONE));
    chk("rd_no_err",     32'(tx_err), 32'h0);
    step(1'b1, 1'b0, 1'b0);

    // ---------------- read-data command with no pending address ----------------
    w = 10'b1111000011;
    send_word(w);
    chk("rn_rx_data", 32'(rx_data), 32'h3C3);
    chk("rn_state",   32'(dut.r_state), st(ST_DONE));
    chk("rn_pending", 32'(rd_addr_pending), 32'h1);
    step(1'b1, 1'b0, 1'b0);

    // ---------------- abort after bit 4 ----------------
    w = 10'b0101010101;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 9; i >= 4; i--) step(1'b0, w[i], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("ab_state",   32'(dut.r_state), st(ST_IDLE));
    chk("ab_valid",   32'(rx_valid), 32'h0);
    chk("ab_rx_data", 32'(rx_data), 32'h3C3);
    step(1'b1, 1'b0, 1'b0);
    chk("ab_valid2",  32'(rx_valid), 32'h0);
    w = 10'b0101101010;
    send_word(w);
    chk("ab_next_data",  32'(rx_data), 32'h16A);
    chk("ab_next_valid", 32'(rx_valid), 32'h1);
    chk("ab_pend_kept",  32'(rd_addr_pending), 32'h1);
    step(1'b1, 1'b0, 1'b0);

    // ---------------- tx_valid timeout ----------------
    w = 10'b1111111111;
    send_word(w);
    chk("to_state", 32'(dut.r_state), st(ST_TX_WAIT));
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("to_no_err_w%0d", k), 32'(tx_err), 32'h0);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("to_err",     32'(tx_err), 32'h1);
    chk("to_done",    32'(dut.r_state), st(ST_DONE));
    chk("to_pending", 32'(rd_addr_pending), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("to_err_drop", 32'(tx_err), 32'h0);
    step(1'b1, 1'b0, 1'b0);

    // ---------------- tx_valid on the final wait edge wins ----------------
    w = 10'b1100000000;
    send_word(w);
    for (int k = 1; k <= 14; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("tb_no_err", 32'(tx_err), 32'h0);
    chk("tb_active", 32'(tx_active), 32'h1);
    chk("tb_state",  32'(dut.r_state), st(ST_TX_SHIFT));
    for (int k = 2; k <= 8; k++) step(1'b0, 1'b0, 1'b0);
    chk("tb_active_c8", 32'(tx_active), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("tb_active_end", 32'(tx_active), 32'h0);
    chk("tb_pend_clear", 32'(rd_addr_pending), 32'h0);
    step(1'b1, 1'b0, 1'b0);

    // ---------------- asynchronous reset during TX_SHIFT ----------------
    w = 10'b1010101010;
    send_word(w);
    chk("rs_pending", 32'(rd_addr_pending), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    w = 10'b1100000000;
    send_word(w);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rs_active_c3", 32'(tx_active), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_rx_data",   32'(rx_data), 32'h0);
    chk("rs_rx_valid",  32'(rx_valid), 32'h0);
    chk("rs_tx_active", 32'(tx_active), 32'h0);
    chk("rs_pending0",  32'(rd_addr_pending), 32'h0);
    chk("rs_tx_err",    32'(tx_err), 32'h0);
    chk("rs_state",     32'(dut.r_state), st(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    SS_n  = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk("rs_idle_after", 32'(dut.r_state), st(ST_IDLE));
    chk("rs_active_after", 32'(tx_active), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
